// File: rtl/mips_pkg.sv
// Shared definitions for the mini-MIPS fetch path: branch-condition codes and default reset PC.
package mips_pkg;

   typedef enum logic [1:0] {
      BR_EQ = 2'd0,
      BR_NE = 2'd1,
      BR_LT = 2'd2,
      BR_GE = 2'd3
   } br_cond_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/mips_ras.sv
// Circular return-address stack with a count register; pushing when full overwrites the oldest entry.
// push+pop on a non-empty stack replaces the top entry in place.
module mips_ras #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     tptr;
   logic [PW:0]       count;
   logic              replace;

   assign tptr    = wptr - 1'b1;
   assign top     = mem[tptr];
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign replace = push && pop && !empty;

   // Contents are not reset; only the count decides validity.
   always_ff @(posedge clk) begin
      if (replace)
         mem[tptr] <= din;
      else if (push)
         mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         count <= '0;
      end else if (replace) begin
         wptr  <= wptr;
      end else if (push) begin
         wptr <= wptr + 1'b1;
         if (!full)
            count <= count + 1'b1;
      end else if (pop && !empty) begin
         wptr  <= tptr;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// PC register and next-PC selection (ret > jr > jump > taken branch > sequential) with RAS, stall and halt.
// One-cycle latency from control inputs to pc; halt_req freezes the PC at the edge it is seen.
module mips_fetch_unit
   import mips_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              branch_en,
   input  logic [1:0]        branch_cond,
   input  logic              alu_zero,
   input  logic              alu_neg,
   input  logic [31:0]       branch_off,
   input  logic              jump_en,
   input  logic [25:0]       jump_target,
   input  logic              jr_en,
   input  logic [31:0]       jr_target,
   input  logic              link,
   input  logic              ret_en,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic              redirect,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_underflow,
   output logic              halted
);

   logic              accept;
   logic              br_taken;
   logic [ADDR_W-1:0] br_target;
   logic [ADDR_W-1:0] jump_pc;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] next_pc;
   logic              next_redirect;
   logic              underflow_set;
   logic              unused_bits;

   assign unused_bits = ^{jr_target, branch_off, jump_target};

   // The cycle that raises halt_req is discarded as well, so the PC freezes on its current value.
   assign accept    = !halted && !stall && !halt_req;
   assign pc_plus1  = pc + 1'b1;
   assign br_target = pc_plus1 + branch_off[ADDR_W-1:0];

   generate
      if (ADDR_W > 26) begin : g_jump_wide
         assign jump_pc = {pc_plus1[ADDR_W-1:26], jump_target};
      end else begin : g_jump_narrow
         assign jump_pc = jump_target[ADDR_W-1:0];
      end
   endgenerate

   always_comb begin
      br_taken = 1'b0;
      case (br_cond_t'(branch_cond))
         BR_EQ: br_taken = alu_zero;
         BR_NE: br_taken = !alu_zero;
         BR_LT: br_taken = alu_neg;
         BR_GE: br_taken = !alu_neg;
         default: br_taken = 1'b0;
      endcase
      br_taken = br_taken && branch_en;
   end

   always_comb begin
      next_pc       = pc_plus1;
      next_redirect = 1'b0;
      underflow_set = 1'b0;
      if (ret_en) begin
         if (ras_empty) begin
            underflow_set = 1'b1;
         end else begin
            next_pc       = ras_top;
            next_redirect = 1'b1;
         end
      end else if (jr_en) begin
         next_pc       = jr_target[ADDR_W-1:0];
         next_redirect = 1'b1;
      end else if (jump_en) begin
         next_pc       = jump_pc;
         next_redirect = 1'b1;
      end else if (br_taken) begin
         next_pc       = br_target;
         next_redirect = 1'b1;
      end
   end

   mips_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept && link),
      .pop   (accept && ret_en),
      .din   (pc_plus1),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC[ADDR_W-1:0];
         redirect      <= 1'b0;
         ras_underflow <= 1'b0;
         halted        <= 1'b0;
      end else begin
         if (halt_req)
            halted <= 1'b1;
         if (accept) begin
            pc       <= next_pc;
            redirect <= next_redirect;
            if (underflow_set)
               ras_underflow <= 1'b1;
         end else begin
            redirect <= 1'b0;
         end
      end
   end

endmodule
